reg_uart_rx: RTL
================

Name: reg_uart_rx

Overview:
Serial-to-parallel receiver for the 32-bit UART word link. It is the receiving end of the RegUart transmitter. It takes the 1-bit serial line, decodes standard 8N1 byte frames (start 0, 8 data bits LSB first, stop 1) and packs 4 consecutive bytes into a 32-bit register. Byte 0 is bits [7:0]. The block flags word completion, framing errors and inter-byte timeouts for the downstream register logic.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 4 and even.
BYTES_PER_WORD, 4, bytes assembled per output word (fixed 4 for 32-bit Q).
TIMEOUT_BITS, 20, idle bit-times between bytes after which a partial word is discarded.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in  input  1  serial line, idle high, asynchronous to clk.
Q  output  32  last completely received word.
valid  output  1  one-cycle pulse when Q is updated.
frame_err  output  1  one-cycle pulse on a bad stop bit.
timeout  output  1  one-cycle pulse when a partial word is discarded.
busy  output  1  high from start-bit detection until the stop bit is sampled.

Behaviour:
- Reset (asynchronous, active-high): Q=0, valid=0, frame_err=0, timeout=0, busy=0. Synchronizer flops are set to 1 (idle), byte_cnt=0, state=IDLE.
- Reset asserted mid-frame aborts the frame immediately. There is no partial output.
- Input sync: 2-flop synchronizer on in. All decoding uses the synchronized bit rx_s, which adds 2 clk of latency.
- Bit timer: counter 0..CLKS_PER_BIT-1. The sample point is count == CLKS_PER_BIT/2-1 (mid-bit).
- State IDLE: wait for rx_s==0, then go to START with the timer cleared.
- State START: at mid-bit, if rx_s==1 it is a glitch: return to IDLE, with no error flag. Otherwise restart the timer for full bit periods and go to DATA with bit_idx=0.
- State DATA: sample rx_s at each subsequent mid-bit and shift it into the byte register LSB first. After bit_idx==7, go to STOP.
- State STOP, good stop bit: at mid-bit, rx_s==1 means the byte is good. Write it into word_sr[8*byte_cnt +: 8] and increment byte_cnt.
  - If byte_cnt was 3: Q <= assembled word, valid=1 for exactly the next clk, byte_cnt=0.
  - Then go to IDLE. Detection of the next start bit is allowed immediately after the stop mid-sample (half stop bit).
- State STOP, bad stop bit: rx_s==0 gives frame_err=1 for one clk. byte_cnt=0 and the partial word is dropped. Go to WAIT_IDLE.
- State WAIT_IDLE: remain until rx_s==1 (break condition), then go to IDLE. Q is unchanged.
- Timeout: while in IDLE with byte_cnt!=0, count clk cycles.
  - At TIMEOUT_BITS*CLKS_PER_BIT cycles: timeout=1 for one clk, byte_cnt=0.
  - The counter clears on leaving IDLE.
  - If a start bit is detected on the same cycle the timeout fires, timeout wins: byte_cnt=0, and the new byte counts as byte 0.
- busy = (state in START, DATA, STOP).
- Q holds its value between words. valid, frame_err and timeout are never high in the same cycle.
- Latency: valid rises 1 clk after the clk edge on which the 4th stop bit is mid-sampled. Q changes on that same edge.

Decomposition:
- Shared package uart_pkg: state enum {IDLE, START, DATA, STOP, WAIT_IDLE}, constants DATA_BITS=8 and BYTE_W=8, and the sample-point function mid(CLKS_PER_BIT). The RegUart side reuses the same frame constants.
- One natural sub-module, uart_rx_byte: synchronizer, bit timer, START/DATA/STOP FSM, outputs byte + byte_ok/byte_err pulses.
- The top module reg_uart_rx adds the byte counter, word assembly, timeout counter and output pulses.

Test Plan:
1. Send word 32'd261 as bytes 0x05, 0x01, 0x00, 0x00, back to back at CLKS_PER_BIT=16 -> a single valid pulse, Q=32'h00000105, frame_err=0, timeout=0.
2. Send 0xEF, 0xBE, 0xAD, 0xDE, then 0x78, 0x56, 0x34, 0x12 -> valid twice. Q=32'hDEADBEEF, then 32'h12345678. Q holds DEADBEEF between the two pulses.
3. Send 2 good bytes, then a byte with stop bit=0, then 4 good bytes 0x11..0x44 -> frame_err pulse once, then valid with Q=32'h44332211. The first 2 bytes are discarded.
4. Drive a 0 glitch of 3 clk on idle in -> no busy beyond the START phase, no valid, no frame_err. State returns to IDLE.
5. Send 3 bytes, idle 21 bit-times, then 4 bytes 0xA0..0xA3 -> timeout pulse at 20 bit-times, then valid with Q=32'hA3A2A1A0.
6. Assert reset during bit 4 of byte 2 -> outputs are 0 immediately (asynchronously). After release, 4 fresh bytes give the correct Q and a single valid pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Frame constants, state encoding and sample-point helper shared by the UART word link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BYTE_W    = 8;

  // Mid-bit sample point of the bit timer.
  function automatic int unsigned mid(input int unsigned clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, bit timer and START/DATA/STOP framing FSM.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_ok_o,
  output logic              byte_err_o,
  output logic              busy_o,
  output logic              idle_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] MidCnt  = CntW'(mid(CLKS_PER_BIT));
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastBit = IdxW'(DATA_BITS - 1);

  logic [1:0]        sync_q;
  logic              rx_s;
  uart_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic              at_mid;

  assign rx_s   = sync_q[1];
  assign at_mid = (cnt_q == MidCnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  // The timer free-runs modulo one bit period once a start edge is seen, so every
  // later mid-bit lands exactly one bit period after the start-bit mid-sample.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    byte_ok_o  = 1'b0;
    byte_err_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (at_mid) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (at_mid) begin
          shreg_d = {rx_s, shreg_q[BYTE_W-1:1]};
          if (bit_idx_q == LastBit) state_d = STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (at_mid) begin
          if (rx_s) begin
            byte_ok_o = 1'b1;
            state_d   = IDLE;
          end else begin
            byte_err_o = 1'b1;
            state_d    = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o = shreg_q;
  assign busy_o = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign idle_o = (state_q == IDLE);

endmodule

// File: rtl/reg_uart_rx.sv
// UART word receiver: packs consecutive 8N1 bytes (byte 0 in the LSBs) into one word and
// flags word completion, framing errors and inter-byte timeouts with one-cycle pulses.
module reg_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 16,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned TIMEOUT_BITS   = 20
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] Q,
  output logic                             valid,
  output logic                             frame_err,
  output logic                             timeout,
  output logic                             busy
);

  localparam int unsigned WordW    = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned IdxW     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned ToCycles = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned ToW      = $clog2(ToCycles + 1);
  localparam logic [IdxW-1:0] LastByte = IdxW'(BYTES_PER_WORD - 1);
  localparam logic [ToW-1:0]  ToLast   = ToW'(ToCycles - 1);

  logic [BYTE_W-1:0] rx_byte;
  logic              byte_ok, byte_err, rx_idle;

  logic [IdxW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [WordW-1:0] word_sr_q, word_sr_d;
  logic [WordW-1:0] q_q, q_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout_q, timeout_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .reset     (reset),
    .rx_i      (in),
    .byte_o    (rx_byte),
    .byte_ok_o (byte_ok),
    .byte_err_o(byte_err),
    .busy_o    (busy),
    .idle_o    (rx_idle)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_q  <= '0;
      word_sr_q   <= '0;
      q_q         <= '0;
      to_cnt_q    <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      word_sr_q   <= word_sr_d;
      q_q         <= q_d;
      to_cnt_q    <= to_cnt_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
    end
  end

  // Byte events only occur outside IDLE and the timeout only inside it, so the three
  // pulses can never coincide; a start bit seen on the firing cycle becomes byte 0.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    word_sr_d   = word_sr_q;
    q_d         = q_q;
    to_cnt_d    = '0;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;

    if (rx_idle && (byte_cnt_q != '0)) begin
      if (to_cnt_q == ToLast) begin
        timeout_d  = 1'b1;
        byte_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (byte_ok) begin
      word_sr_d[BYTE_W*byte_cnt_q +: BYTE_W] = rx_byte;
      if (byte_cnt_q == LastByte) begin
        q_d        = word_sr_d;
        valid_d    = 1'b1;
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end

    if (byte_err) begin
      frame_err_d = 1'b1;
      byte_cnt_d  = '0;
    end
  end

  assign Q         = q_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign timeout   = timeout_q;

endmodule
